// File: rtl/spi_master_engine_if.sv
// Register-file side of the SPI shift engine: transfer request, mode config, serial pins and result.
interface spi_master_engine_if;
  logic        en_i;
  logic        start_i;
  logic [2:0]  nbytes_i;
  logic [31:0] tx_data_i;
  logic        cpol_i;
  logic        cpha_i;
  logic [1:0]  div_i;
  logic        spi_miso_i;
  logic        spi_mosi_o;
  logic        spi_clk_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rx_data_o;

  modport master (
    output en_i, start_i, nbytes_i, tx_data_i, cpol_i, cpha_i, div_i, spi_miso_i,
    input  spi_mosi_o, spi_clk_o, busy_o, done_o, rx_data_o
  );

  modport slave (
    input  en_i, start_i, nbytes_i, tx_data_i, cpol_i, cpha_i, div_i, spi_miso_i,
    output spi_mosi_o, spi_clk_o, busy_o, done_o, rx_data_o
  );
endinterface

// File: rtl/spi_master_engine.sv
// 1-4 byte SPI shift engine (modes 0-3, SCK half-period 2/4/8/16 clk); start-to-done_o is 16*n*H+1 cycles.
// No backpressure: a start is dropped, never queued, unless idle, enabled and nbytes in 1..4.
module spi_master_engine (
  input  logic               clk_i,
  input  logic               rst_i,
  spi_master_engine_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] tx_sr_q, tx_sr_d;
  logic [31:0] rx_sr_q, rx_sr_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [1:0]  div_q, div_d;
  logic        cpol_q, cpol_d;
  logic        cpha_q, cpha_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  edge_q, edge_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;

  logic [31:0] tx_ord, rx_ord;
  logic [3:0]  half_m1;
  logic [6:0]  last_edge;
  logic        start_ok, tick, sample;

  // Byte 0 is sent first, MSB first: byte-swap so the wire order is simply bit 31 downwards.
  assign tx_ord    = {bus.tx_data_i[7:0], bus.tx_data_i[15:8], bus.tx_data_i[23:16], bus.tx_data_i[31:24]};
  assign start_ok  = bus.start_i && bus.en_i && (bus.nbytes_i != 3'd0) && (bus.nbytes_i <= 3'd4);
  assign last_edge = {nbytes_q, 4'b0000} - 7'd1;
  assign tick      = (cnt_q == half_m1);
  assign sample    = ~edge_q[0] ^ cpha_q;

  always_comb begin
    unique case (div_q)
      2'd0:    half_m1 = 4'd1;
      2'd1:    half_m1 = 4'd3;
      2'd2:    half_m1 = 4'd7;
      default: half_m1 = 4'd15;
    endcase
  end

  // The last received byte sits lowest in rx_sr; swap the low n bytes back into transmit order.
  always_comb begin
    unique case (nbytes_q)
      3'd1:    rx_ord = {24'h0, rx_sr_q[7:0]};
      3'd2:    rx_ord = {16'h0, rx_sr_q[7:0], rx_sr_q[15:8]};
      3'd3:    rx_ord = {8'h0, rx_sr_q[7:0], rx_sr_q[15:8], rx_sr_q[23:16]};
      default: rx_ord = {rx_sr_q[7:0], rx_sr_q[15:8], rx_sr_q[23:16], rx_sr_q[31:24]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    nbytes_d  = nbytes_q;
    div_d     = div_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sck_d  = bus.cpol_i;
        mosi_d = 1'b0;
        if (start_ok) begin
          state_d  = ST_SHIFT;
          nbytes_d = bus.nbytes_i;
          div_d    = bus.div_i;
          cpol_d   = bus.cpol_i;
          cpha_d   = bus.cpha_i;
          cnt_d    = '0;
          edge_d   = '0;
          rx_sr_d  = '0;
          // CPHA=0 puts bit 7 on the wire now; CPHA=1 waits for the first leading edge.
          if (bus.cpha_i) begin
            tx_sr_d = tx_ord;
          end else begin
            tx_sr_d = tx_ord << 1;
            mosi_d  = tx_ord[31];
          end
        end
      end
      ST_SHIFT: begin
        if (!bus.en_i) begin
          state_d = ST_IDLE;
          sck_d   = bus.cpol_i;
          mosi_d  = 1'b0;
        end else if (tick) begin
          cnt_d  = '0;
          sck_d  = ~sck_q;
          edge_d = edge_q + 7'd1;
          if (sample) begin
            rx_sr_d = {rx_sr_q[30:0], bus.spi_miso_i};
          end else if (edge_q != last_edge) begin
            mosi_d  = tx_sr_q[31];
            tx_sr_d = tx_sr_q << 1;
          end
          if (edge_q == last_edge) state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        rx_data_d = rx_ord;
        sck_d     = cpol_q;
        mosi_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      nbytes_q  <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      cnt_q     <= '0;
      edge_q    <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      nbytes_q  <= nbytes_d;
      div_q     <= div_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign bus.spi_clk_o  = sck_q;
  assign bus.spi_mosi_o = mosi_q;
  assign bus.busy_o     = (state_q == ST_SHIFT);
  assign bus.done_o     = done_q;
  assign bus.rx_data_o  = rx_data_q;
endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine: loopback / scripted slave on the serial pins, SCK edge monitor.
module tb_spi_master_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_engine_if bus();
  spi_master_engine dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        loop_en  = 1'b1;
  logic        slv_miso = 1'b0;
  logic [31:0] slv_tx   = 32'h0;
  logic [31:0] slv_rx   = 32'h0;
  assign bus.spi_miso_i = loop_en ? bus.spi_mosi_o : slv_miso;

  int   n_edges = 0, first_cyc = 0, last_cyc = 0, gap_err = 0, mosi_bad = 0, done_cnt = 0;
  int   exp_h = 2;
  logic mon_cpol = 1'b0, mon_cpha = 1'b0;
  logic sck_prev = 1'b0, mosi_prev = 1'b0;

  // SCK edge monitor plus a CPHA=1 slave (drives on leading edges, captures on trailing edges).
  always @(negedge clk) begin
    logic lead;
    lead = 1'b0;
    if (bus.done_o === 1'b1) done_cnt++;
    if (bus.spi_clk_o !== sck_prev) begin
      n_edges++;
      if (n_edges == 1) first_cyc = cyc;
      else if (cyc - last_cyc != exp_h) gap_err++;
      last_cyc = cyc;
      lead = (sck_prev === mon_cpol);
      if (mon_cpha) begin
        if (lead) begin
          slv_miso = slv_tx[31];
          slv_tx   = slv_tx << 1;
        end else begin
          slv_rx = {slv_rx[30:0], bus.spi_mosi_o};
        end
      end
    end
    if (bus.spi_mosi_o !== mosi_prev && bus.busy_o === 1'b1 && mon_cpha && !lead) mosi_bad++;
    sck_prev  = bus.spi_clk_o;
    mosi_prev = bus.spi_mosi_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic cpol, input logic cpha, input logic [1:0] div,
                     input logic [2:0] n, input logic [31:0] tx);
    bus.cpol_i = cpol; bus.cpha_i = cpha; bus.div_i = div;
    bus.nbytes_i = n; bus.tx_data_i = tx;
    mon_cpol = cpol; mon_cpha = cpha; exp_h = 2 << int'(div);
    tick(); tick();
    n_edges = 0; gap_err = 0; mosi_bad = 0; first_cyc = 0; last_cyc = 0;
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done_o === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (bus.spi_clk_o !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", bus.spi_clk_o); end
    total++; if (bus.spi_mosi_o !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", bus.spi_mosi_o); end
    total++; if ({bus.busy_o, bus.done_o} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b exp=00", {bus.busy_o, bus.done_o}); end
    total++; if (bus.rx_data_o !== 32'h0) begin bad++; $display("FAIL reset_rx got=%h exp=00000000", bus.rx_data_o); end
    rst = 1'b0;
    bus.en_i = 1'b1;
    tick();
  endtask

  task automatic test_mode0();
    int lat;
    loop_en = 1'b1;
    cfg(1'b0, 1'b0, 2'd0, 3'd1, 32'h0000_00A5);
    total++; if (bus.spi_clk_o !== 1'b0) begin bad++; $display("FAIL m0_idle_sck got=%b exp=0", bus.spi_clk_o); end
    pulse_start();
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL m0_busy got=%b exp=1", bus.busy_o); end
    wait_done(200, lat);
    total++; if (lat != 33) begin bad++; $display("FAIL m0_latency got=%0d exp=33", lat); end
    total++; if (bus.rx_data_o !== 32'h0000_00A5) begin bad++; $display("FAIL m0_rx got=%h exp=000000a5", bus.rx_data_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL m0_busy_at_done got=%b exp=0", bus.busy_o); end
    total++; if (n_edges != 16) begin bad++; $display("FAIL m0_edges got=%0d exp=16", n_edges); end
    total++; if (gap_err != 0) begin bad++; $display("FAIL m0_edge_gap got=%0d exp=0", gap_err); end
    total++; if (first_cyc - t0 != 2) begin bad++; $display("FAIL m0_first_edge got=%0d exp=2", first_cyc - t0); end
    tick();
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL m0_done_pulse got=%b exp=0", bus.done_o); end
    total++; if (bus.spi_clk_o !== 1'b0) begin bad++; $display("FAIL m0_end_sck got=%b exp=0", bus.spi_clk_o); end
  endtask

  task automatic test_mode3();
    int lat;
    loop_en = 1'b0;
    cfg(1'b1, 1'b1, 2'd3, 3'd4, 32'h1234_5678);
    slv_tx = 32'h0DF0_FECA;
    slv_rx = 32'h0;
    total++; if (bus.spi_clk_o !== 1'b1) begin bad++; $display("FAIL m3_idle_sck got=%b exp=1", bus.spi_clk_o); end
    pulse_start();
    wait_done(1200, lat);
    total++; if (lat != 1025) begin bad++; $display("FAIL m3_latency got=%0d exp=1025", lat); end
    total++; if (bus.rx_data_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL m3_rx got=%h exp=cafef00d", bus.rx_data_o); end
    total++; if (slv_rx !== 32'h7856_3412) begin bad++; $display("FAIL m3_slave_rx got=%h exp=78563412", slv_rx); end
    total++; if (n_edges != 64) begin bad++; $display("FAIL m3_edges got=%0d exp=64", n_edges); end
    total++; if (gap_err != 0) begin bad++; $display("FAIL m3_edge_gap got=%0d exp=0", gap_err); end
    total++; if (bus.spi_clk_o !== 1'b1) begin bad++; $display("FAIL m3_end_sck got=%b exp=1", bus.spi_clk_o); end
    loop_en = 1'b1;
  endtask

  task automatic test_mode1();
    int lat;
    loop_en = 1'b1;
    cfg(1'b0, 1'b1, 2'd1, 3'd2, 32'h0000_BEEF);
    pulse_start();
    wait_done(300, lat);
    total++; if (lat != 129) begin bad++; $display("FAIL m1_latency got=%0d exp=129", lat); end
    total++; if (bus.rx_data_o !== 32'h0000_BEEF) begin bad++; $display("FAIL m1_rx got=%h exp=0000beef", bus.rx_data_o); end
    total++; if (mosi_bad != 0) begin bad++; $display("FAIL m1_mosi_on_trailing got=%0d exp=0", mosi_bad); end
    total++; if (n_edges != 32) begin bad++; $display("FAIL m1_edges got=%0d exp=32", n_edges); end
  endtask

  task automatic test_illegal();
    int d0;
    logic [2:0] nb;
    for (int k = 0; k < 3; k++) begin
      nb = (k == 0) ? 3'd0 : (k == 1) ? 3'd5 : 3'd1;
      cfg(1'b0, 1'b0, 2'd0, nb, 32'h0000_00FF);
      bus.en_i = (k != 2);
      d0 = done_cnt;
      pulse_start();
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL illegal_busy case=%0d got=%b exp=0", k, bus.busy_o); end
      repeat (40) tick();
      total++; if (done_cnt != d0) begin bad++; $display("FAIL illegal_done case=%0d got=%0d exp=%0d", k, done_cnt, d0); end
    end
    bus.en_i = 1'b1;
    total++; if (bus.rx_data_o !== 32'h0000_BEEF) begin bad++; $display("FAIL illegal_rx got=%h exp=0000beef", bus.rx_data_o); end
  endtask

  task automatic test_back_to_back();
    int lat;
    loop_en = 1'b1;
    cfg(1'b0, 1'b0, 2'd0, 3'd1, 32'h0000_005A);
    pulse_start();
    repeat (10) tick();
    bus.nbytes_i = 3'd4; bus.tx_data_i = 32'hFFFF_FFFF; bus.div_i = 2'd3;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    wait_done(200, lat);
    total++; if (lat != 33) begin bad++; $display("FAIL busy_start_latency got=%0d exp=33", lat); end
    total++; if (bus.rx_data_o !== 32'h0000_005A) begin bad++; $display("FAIL busy_start_rx got=%h exp=0000005a", bus.rx_data_o); end
    bus.nbytes_i = 3'd1; bus.tx_data_i = 32'h0000_00C3; bus.div_i = 2'd0;
    pulse_start();
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", bus.busy_o); end
    wait_done(200, lat);
    total++; if (lat != 33) begin bad++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    total++; if (bus.rx_data_o !== 32'h0000_00C3) begin bad++; $display("FAIL b2b_rx got=%h exp=000000c3", bus.rx_data_o); end
  endtask

  task automatic test_abort();
    int lat, d0;
    bit reached;
    loop_en = 1'b1;
    cfg(1'b0, 1'b0, 2'd0, 3'd1, 32'h0000_003C);
    d0 = done_cnt;
    pulse_start();
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (n_edges >= 5) begin reached = 1'b1; break; end
      tick();
    end
    total++; if (!reached) begin bad++; $display("FAIL abort_wait_edges got=%0d exp=5", n_edges); end
    bus.en_i = 1'b0;
    tick();
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy_o); end
    total++; if (bus.spi_clk_o !== 1'b0) begin bad++; $display("FAIL abort_sck got=%b exp=0", bus.spi_clk_o); end
    total++; if (bus.spi_mosi_o !== 1'b0) begin bad++; $display("FAIL abort_mosi got=%b exp=0", bus.spi_mosi_o); end
    total++; if (bus.rx_data_o !== 32'h0000_00C3) begin bad++; $display("FAIL abort_rx got=%h exp=000000c3", bus.rx_data_o); end
    repeat (60) tick();
    total++; if (done_cnt != d0) begin bad++; $display("FAIL abort_done got=%0d exp=%0d", done_cnt, d0); end
    bus.en_i = 1'b1;
    tick();
    pulse_start();
    wait_done(200, lat);
    total++; if (lat != 33) begin bad++; $display("FAIL abort_restart_latency got=%0d exp=33", lat); end
    total++; if (bus.rx_data_o !== 32'h0000_003C) begin bad++; $display("FAIL abort_restart_rx got=%h exp=0000003c", bus.rx_data_o); end
  endtask

  task automatic test_reset_mid();
    int d0;
    loop_en = 1'b1;
    cfg(1'b1, 1'b0, 2'd2, 3'd4, 32'h8765_4321);
    pulse_start();
    repeat (50) tick();
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.spi_clk_o !== 1'b0) begin bad++; $display("FAIL rstmid_sck got=%b exp=0", bus.spi_clk_o); end
    total++; if (bus.spi_mosi_o !== 1'b0) begin bad++; $display("FAIL rstmid_mosi got=%b exp=0", bus.spi_mosi_o); end
    total++; if ({bus.busy_o, bus.done_o} !== 2'b00) begin bad++; $display("FAIL rstmid_busy_done got=%b exp=00", {bus.busy_o, bus.done_o}); end
    total++; if (bus.rx_data_o !== 32'h0) begin bad++; $display("FAIL rstmid_rx got=%h exp=00000000", bus.rx_data_o); end
    repeat (600) tick();
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rstmid_done got=%0d exp=%0d", done_cnt, d0); end
    total++; if (bus.spi_clk_o !== 1'b1) begin bad++; $display("FAIL rstmid_idle_sck got=%b exp=1", bus.spi_clk_o); end
  endtask

  initial begin
    bus.en_i = 1'b0; bus.start_i = 1'b0; bus.nbytes_i = 3'd0; bus.tx_data_i = 32'h0;
    bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.div_i = 2'd0;
    test_reset();
    test_mode0();
    test_mode3();
    test_mode1();
    test_illegal();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
